// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST pattern generator and its LFSR
package bist_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;
    localparam logic [LFSR_W-1:0] RESET_SEED = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // One Fibonacci step of x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit maximal-length LFSR with synchronous load and step enable
module lfsr8
    import bist_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] din,
    output logic [LFSR_W-1:0] q
);

    // Load wins over stepping; a zero seed is replaced so the register can never lock up
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            q <= RESET_SEED;
        else if (load)
            q <= (din == '0) ? RESET_SEED : din;
        else if (en)
            q <= lfsr_next(q);
    end

endmodule

// File: rtl/bist_tpg.sv
// bist_tpg: BIST test pattern generator emitting a counted run of LFSR patterns
module bist_tpg
    import bist_pkg::*;
#(
    parameter int LFSR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [LFSR_W-1:0] seed,
    input  logic              seed_ld,
    input  logic [CNT_W-1:0]  n_pat,
    input  logic              start,
    input  logic              abort,
    output logic              e0,
    output logic              e1,
    output logic              e2,
    output logic              pat_valid,
    output logic              busy,
    output logic              done,
    output logic [LFSR_W-1:0] lfsr_q
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] npat_q;
    logic             load;
    logic             step;

    assign load = (state == IDLE) && seed_ld;
    assign step = (state == RUN);
    assign e0   = lfsr_q[0];
    assign e1   = lfsr_q[1];
    assign e2   = lfsr_q[2];

    lfsr8 u_lfsr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (load),
        .en    (step),
        .din   (seed),
        .q     (lfsr_q)
    );

    // Run sequencing: counts emitted patterns and registers the status flags alongside the state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            npat_q    <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt       <= '0;
                    npat_q    <= n_pat;
                    state     <= (n_pat == '0) ? DONE : RUN;
                    pat_valid <= (n_pat != '0);
                    done      <= (n_pat == '0);
                    busy      <= 1'b1;
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (abort) begin
                        state     <= IDLE;
                        pat_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt == npat_q - CNT_W'(1)) begin
                        state     <= DONE;
                        pat_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_tpg.sv
// tb_bist_tpg: self-checking bench for bist_tpg against an arithmetic LFSR reference
module tb_bist_tpg;

    logic       CLK;
    logic       RST_N;
    logic [7:0] seed;
    logic       seed_ld;
    logic [7:0] n_pat;
    logic       start;
    logic       abort;
    logic       e0, e1, e2;
    logic       pat_valid, busy, done;
    logic [7:0] lfsr_q;

    int checks   = 0;
    int failures = 0;
    logic [7:0] m_lfsr;
    int pats[$];

    bist_tpg #(.LFSR_W(8), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .seed      (seed),
        .seed_ld   (seed_ld),
        .n_pat     (n_pat),
        .start     (start),
        .abort     (abort),
        .e0        (e0),
        .e1        (e1),
        .e2        (e2),
        .pat_valid (pat_valid),
        .busy      (busy),
        .done      (done),
        .lfsr_q    (lfsr_q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [7:0] seed;
        int         n;
        logic [7:0] exp_load;
        int         exp_first;
        logic [7:0] exp_end;
    } vec_t;

    // Reference step: double modulo 256, plus parity of taps 7,5,4,3 as the new low bit
    function automatic logic [7:0] model_step(input logic [7:0] q);
        int fb;
        fb = $countones(q & 8'hB8) % 2;
        return 8'((int'(q) * 2) % 256 + fb);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_check(input logic ld, input logic [7:0] s, input int n);
        logic [7:0] m;
        bit seen [256];
        int rep;
        rep = 0;
        m = ld ? ((s == 8'h00) ? 8'h01 : s) : m_lfsr;
        seed = s; seed_ld = ld; n_pat = 8'(n); start = 1'b1; abort = 1'b0;
        tick();
        for (int k = 0; k < n; k++) begin
            chk("run_valid", int'(pat_valid), 1);
            chk("run_busy", int'(busy), 1);
            chk("run_done_low", int'(done), 0);
            chk("run_pattern", int'({e2, e1, e0}), int'(m[2:0]));
            chk("run_lfsr", int'(lfsr_q), int'(m));
            if (seen[lfsr_q]) rep++;
            seen[lfsr_q] = 1'b1;
            pats.push_back(int'({e2, e1, e0}));
            m = model_step(m);
            start = 1'($urandom); seed_ld = 1'($urandom);
            seed = 8'($urandom); n_pat = 8'($urandom);
            tick();
        end
        start = 1'b0; seed_ld = 1'b0;
        chk("done_pulse", int'(done), 1);
        chk("done_valid_low", int'(pat_valid), 0);
        chk("done_busy", int'(busy), 1);
        chk("done_lfsr", int'(lfsr_q), int'(m));
        chk("no_repeat", rep, 0);
        tick();
        chk("idle_done_low", int'(done), 0);
        chk("idle_busy_low", int'(busy), 0);
        chk("idle_lfsr_hold", int'(lfsr_q), int'(m));
        m_lfsr = m;
    endtask

    task automatic abort_run(input logic [7:0] s, input int n, input int at);
        logic [7:0] m;
        int nv;
        nv = 0;
        m = (s == 8'h00) ? 8'h01 : s;
        seed = s; seed_ld = 1'b1; n_pat = 8'(n); start = 1'b1; abort = 1'b0;
        tick();
        for (int k = 0; k < at; k++) begin
            nv += int'(pat_valid);
            chk("abort_pattern", int'({e2, e1, e0}), int'(m[2:0]));
            chk("abort_lfsr", int'(lfsr_q), int'(m));
            m = model_step(m);
            start = 1'b1; seed_ld = 1'b1; seed = 8'hAA; n_pat = 8'($urandom);
            abort = (k == at - 1);
            tick();
        end
        abort = 1'b0; start = 1'b0; seed_ld = 1'b0;
        chk("abort_nvalid", nv, at);
        chk("abort_valid_low", int'(pat_valid), 0);
        chk("abort_no_done", int'(done), 0);
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_lfsr_end", int'(lfsr_q), int'(m));
        tick();
        chk("abort_no_done_late", int'(done), 0);
        chk("abort_still_idle", int'(busy), 0);
        m_lfsr = m;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_lfsr"}, int'(lfsr_q), 8'h01);
        chk({tag, "_valid"}, int'(pat_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pattern"}, int'({e2, e1, e0}), 1);
    endtask

    initial begin
        vec_t vecs[8];
        int exp6[6];
        vecs[0] = '{8'h01, 4,   8'h01, 1, 8'h11};
        vecs[1] = '{8'h00, 255, 8'h01, 1, 8'h01};
        vecs[2] = '{8'h55, 0,   8'h55, 0, 8'h55};
        vecs[3] = '{8'h08, 2,   8'h08, 0, 8'h23};
        vecs[4] = '{8'h80, 1,   8'h80, 0, 8'h01};
        vecs[5] = '{8'hFF, 1,   8'hFF, 7, 8'hFE};
        vecs[6] = '{8'h23, 1,   8'h23, 3, 8'h47};
        vecs[7] = '{8'h01, 1,   8'h01, 1, 8'h02};
        exp6 = '{1, 2, 4, 0, 1, 3};

        RST_N = 1'b1; seed = '0; seed_ld = 1'b0; n_pat = '0; start = 1'b0; abort = 1'b0;
        #1 RST_N = 1'b0;
        #1 chk_reset_vals("reset_async");
        #5 RST_N = 1'b1;
        tick();
        chk_reset_vals("reset_release");
        m_lfsr = 8'h01;

        for (int i = 0; i < 8; i++) begin
            seed = vecs[i].seed; seed_ld = 1'b1;
            tick();
            seed_ld = 1'b0;
            chk("seed_load", int'(lfsr_q), int'(vecs[i].exp_load));
            m_lfsr = vecs[i].exp_load;
            pats.delete();
            run_check(1'b0, 8'h00, vecs[i].n);
            if (vecs[i].n != 0) chk("first_pattern", pats[0], vecs[i].exp_first);
            chk("end_lfsr", int'(lfsr_q), int'(vecs[i].exp_end));
        end

        pats.delete();
        run_check(1'b1, 8'h01, 3);
        run_check(1'b0, 8'h00, 3);
        chk("b2b_count", pats.size(), 6);
        for (int i = 0; i < 6 && i < pats.size(); i++) chk("b2b_pattern", pats[i], exp6[i]);

        pats.delete();
        run_check(1'b1, 8'h23, 2);
        chk("ld_start_first", pats[0], 3);

        abort_run(8'h01, 10, 3);
        abort_run(8'h01, 3, 3);

        seed = 8'h01; seed_ld = 1'b1; n_pat = 8'd6; start = 1'b1;
        tick();
        seed_ld = 1'b0; start = 1'b0;
        tick();
        chk("midrun_pattern", int'({e2, e1, e0}), 2);
        RST_N = 1'b0;
        #1 chk_reset_vals("midrun_reset");
        #3 RST_N = 1'b1;
        tick();
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_done", int'(done), 0);
        chk("post_reset_valid", int'(pat_valid), 0);
        pats.delete();
        run_check(1'b1, 8'h01, 3);
        chk("post_reset_count", pats.size(), 3);
        for (int i = 0; i < 3 && i < pats.size(); i++) chk("post_reset_pattern", pats[i], exp6[i]);

        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0)
                run_check(1'($urandom), 8'($urandom), $urandom_range(1, 40));
            else
                abort_run(8'($urandom), $urandom_range(2, 20), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
